// File: rtl/serial_acc_reg_if.sv
// Bus of the bit-serial accumulator: operation request, serial addend and result/status.
// The bench drives the master side and the accumulator takes the slave side.
interface serial_acc_reg_if #(
    parameter int WORD_BITS = 29
);
    logic                 start;
    logic [1:0]           op;
    logic                 chain;
    logic                 ad_in;
    logic                 word_t1;
    logic                 ser_out;
    logic [WORD_BITS-1:0] acc_q;
    logic                 busy;
    logic                 done;
    logic                 ovf;
    logic                 zero;

    modport master (
        output start, op, chain, ad_in,
        input  word_t1, ser_out, acc_q, busy, done, ovf, zero
    );

    modport slave (
        input  start, op, chain, ad_in,
        output word_t1, ser_out, acc_q, busy, done, ovf, zero
    );
endinterface

// File: rtl/serial_acc_reg.sv
// Bit-serial accumulator register: one result bit per clock, LSB first.
// Each operation occupies one full word time that is aligned to the LSB time.
module serial_acc_reg #(
    parameter int WORD_BITS = 29
) (
    input logic             CLOCK,
    input logic             rst,
    serial_acc_reg_if.slave bus
);
    localparam int CW = $clog2(WORD_BITS);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t               state;
    state_t               state_next;
    logic                 window;
    logic [CW-1:0]        count;
    logic [WORD_BITS-1:0] acc;
    logic [WORD_BITS-1:0] acc_next;
    logic [1:0]           op_r;
    logic                 chain_r;
    logic                 carry;
    logic                 saved_carry;
    logic                 done_r;
    logic                 ovf_r;
    logic                 zero_r;
    logic                 r_bit;
    logic                 a_bit;
    logic                 first_cin;
    logic                 cin;
    logic                 sum;
    logic                 cout;
    logic                 last_bit;
    logic                 arith;

    assign last_bit = (count == LAST);
    assign arith    = ~op_r[1];

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // An accepted request waits in ARMED until the next LSB time opens the window.
    always_comb begin
        state_next = state;
        window     = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_next = ARMED;
            ARMED:   if (count == '0) begin
                         window     = 1'b1;
                         state_next = ACTIVE;
                     end
            ACTIVE:  begin
                         window = 1'b1;
                         if (last_bit) state_next = IDLE;
                     end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        r_bit     = 1'b0;
        a_bit     = 1'b0;
        first_cin = 1'b0;
        case (op_r)
            OP_ADD:  begin
                         r_bit     = acc[count];
                         a_bit     = bus.ad_in;
                         first_cin = chain_r & saved_carry;
                     end
            OP_SUB:  begin
                         r_bit     = acc[count];
                         a_bit     = ~bus.ad_in;
                         first_cin = chain_r ? saved_carry : 1'b1;
                     end
            OP_LOAD: a_bit = bus.ad_in;
            default: ;
        endcase
        cin             = (count == '0) ? first_cin : carry;
        sum             = r_bit ^ a_bit ^ cin;
        cout            = (r_bit & a_bit) | (r_bit & cin) | (a_bit & cin);
        acc_next        = acc;
        acc_next[count] = sum;
    end

    // Only ADD/SUB update the saved carry, so a LOAD between chained words keeps it.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            acc         <= '0;
            op_r        <= OP_ADD;
            chain_r     <= 1'b0;
            carry       <= 1'b0;
            saved_carry <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b1;
        end else begin
            count  <= last_bit ? '0 : count + CW'(1);
            done_r <= (state == ACTIVE) && last_bit;
            if (state == IDLE && bus.start) begin
                op_r    <= bus.op;
                chain_r <= bus.chain;
                ovf_r   <= 1'b0;
            end
            if (window) begin
                acc   <= acc_next;
                carry <= cout;
                if (last_bit) begin
                    zero_r <= (acc_next == '0);
                    ovf_r  <= arith & (cin ^ cout);
                    if (arith) saved_carry <= cout;
                end
            end
        end
    end

    assign bus.word_t1 = (count == '0);
    assign bus.ser_out = acc[count];
    assign bus.acc_q   = acc;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.zero    = zero_r;
endmodule

// File: tb/tb_serial_acc_reg.sv
// Self-checking bench for serial_acc_reg at WORD_BITS = 8: directed table,
// mid-window reset, then random operations against a word-level arithmetic model.
module tb_serial_acc_reg;
    localparam int W = 8;

    typedef struct {
        logic [1:0]   op;
        logic         chain;
        logic [W-1:0] a;
        int           start_count;
        logic         extra;
        logic [W-1:0] exp_acc;
        logic         exp_ovf;
        logic         exp_zero;
    } vec_t;

    logic clock;
    logic rst;

    serial_acc_reg_if #(.WORD_BITS(W)) bus ();

    serial_acc_reg #(.WORD_BITS(W)) dut (
        .CLOCK (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int           vectors;
    int           miscompares;
    int           mcount;
    logic [W-1:0] cur_a;
    logic [W-1:0] model_acc;
    logic         model_saved;
    logic         model_ovf;
    logic         model_zero;
    vec_t         vecs [15];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One bit time: outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        mcount     = (mcount + 1) % W;
        bus.ad_in  = cur_a[mcount];
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic chain, input logic [W-1:0] a,
                                  input int start_count, input logic extra,
                                  output logic [W-1:0] obs_acc, output logic obs_ovf, output logic obs_zero);
        int           dd;
        logic [W:0]   full;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_ovf;
        logic         exp_cout;
        logic         cin;
        cur_a     = a;
        bus.ad_in = cur_a[mcount];
        if (start_count >= 0) begin
            while (mcount != start_count) step();
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.chain = chain;
        check_output("busy_at_start", bus.busy, 1'b0);
        dd = 2 * W - mcount;

        b = '0;
        cin = 1'b0;
        exp_cout = 1'b0;
        case (op)
            2'b00: begin b = a;  cin = chain ? model_saved : 1'b0; end
            2'b01: begin b = ~a; cin = chain ? model_saved : 1'b1; end
            default: ;
        endcase
        if (op < 2'b10) begin
            full     = {1'b0, model_acc} + {1'b0, b} + cin;
            exp_res  = full[W-1:0];
            exp_cout = full[W];
            exp_ovf  = (model_acc[W-1] == b[W-1]) && (exp_res[W-1] != model_acc[W-1]);
        end else begin
            exp_res = (op == 2'b10) ? a : '0;
            exp_ovf = 1'b0;
        end

        step();
        bus.start = 1'b0;
        obs_acc  = '0;
        obs_ovf  = 1'b0;
        obs_zero = 1'b0;
        for (int d = 1; d <= dd; d++) begin
            check_output("word_t1", bus.word_t1, mcount == 0);
            check_output("busy", bus.busy, d < dd);
            check_output("done", bus.done, d == dd);
            if (d == 1) check_output("ovf_cleared", bus.ovf, 1'b0);
            if (d == dd) begin
                check_output("acc_q", bus.acc_q, exp_res);
                check_output("ovf", bus.ovf, exp_ovf);
                check_output("zero", bus.zero, exp_res == '0);
                check_output("ser_out", bus.ser_out, exp_res[0]);
                obs_acc  = bus.acc_q;
                obs_ovf  = bus.ovf;
                obs_zero = bus.zero;
            end else begin
                if (extra && d == 2) begin
                    bus.start = 1'b1;
                    bus.op    = ~op;
                    bus.chain = ~chain;
                end
                step();
                bus.start = 1'b0;
            end
        end

        model_acc = exp_res;
        if (op < 2'b10) model_saved = exp_cout;
        model_ovf  = exp_ovf;
        model_zero = (exp_res == '0);
    endtask

    initial begin
        logic [W-1:0] oa;
        logic         oo;
        logic         oz;
        vectors     = 0;
        miscompares = 0;
        mcount      = 0;
        cur_a       = '0;
        model_acc   = '0;
        model_saved = 1'b0;
        model_ovf   = 1'b0;
        model_zero  = 1'b1;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.chain   = 1'b0;
        bus.ad_in   = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        rst    = 1'b1;
        mcount = 0;
        check_output("rst_word_t1", bus.word_t1, 1'b1);
        check_output("rst_acc_q", bus.acc_q, 8'h00);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_done", bus.done, 1'b0);
        check_output("rst_ovf", bus.ovf, 1'b0);
        check_output("rst_zero", bus.zero, 1'b1);
        check_output("rst_ser_out", bus.ser_out, 1'b0);

        vecs[0]  = '{2'b10, 1'b0, 8'h35, -1, 1'b0, 8'h35, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 8'h4A, -1, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 1'b0, 8'h10, -1, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 1'b0, 8'h10, -1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{2'b00, 1'b1, 8'h00, -1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 1'b0, 8'hFF, -1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 1'b0, 8'h01, -1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{2'b10, 1'b0, 8'h00, -1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{2'b00, 1'b1, 8'h00, -1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 1'b1, 8'hFF, -1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 1'b0, 8'h7F, -1, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[11] = '{2'b00, 1'b0, 8'h01, -1, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[12] = '{2'b10, 1'b0, 8'h80,  3, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[13] = '{2'b01, 1'b0, 8'h01, -1, 1'b0, 8'h7F, 1'b1, 1'b0};
        vecs[14] = '{2'b01, 1'b1, 8'h7F,  7, 1'b1, 8'h00, 1'b0, 1'b1};

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].chain, vecs[i].a, vecs[i].start_count, vecs[i].extra, oa, oo, oz);
            check_output("tbl_acc_q", oa, vecs[i].exp_acc);
            check_output("tbl_ovf", oo, vecs[i].exp_ovf);
            check_output("tbl_zero", oz, vecs[i].exp_zero);
        end

        // Reset during window bit 4 of an ADD must abort it without a done pulse.
        apply_stimulus(2'b10, 1'b0, 8'h33, -1, 1'b0, oa, oo, oz);
        cur_a     = 8'h11;
        bus.ad_in = cur_a[mcount];
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.chain = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (11) step();
        rst = 1'b0;
        #1;
        check_output("abort_acc_q", bus.acc_q, 8'h00);
        check_output("abort_busy", bus.busy, 1'b0);
        check_output("abort_done", bus.done, 1'b0);
        check_output("abort_zero", bus.zero, 1'b1);
        check_output("abort_ovf", bus.ovf, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst         = 1'b1;
        mcount      = 0;
        model_acc   = '0;
        model_saved = 1'b0;
        model_ovf   = 1'b0;
        model_zero  = 1'b1;
        check_output("release_word_t1", bus.word_t1, 1'b1);
        check_output("release_busy", bus.busy, 1'b0);
        for (int i = 0; i < 2 * W; i++) begin
            step();
            check_output("post_rst_done", bus.done, 1'b0);
            check_output("post_rst_busy", bus.busy, 1'b0);
            check_output("post_rst_acc_q", bus.acc_q, 8'h00);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rop;
            logic         rch;
            logic [W-1:0] ra;
            int           rsc;
            logic         rex;
            rop = 2'($urandom_range(0, 3));
            rch = 1'($urandom_range(0, 1));
            ra  = W'($urandom);
            rsc = $urandom_range(0, W);
            if (rsc == W) rsc = -1;
            rex = 1'($urandom_range(0, 1));
            apply_stimulus(rop, rch, ra, rsc, rex, oa, oo, oz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
